// File: rtl/seq_detect_sched_if.sv
// Request/result and detector-side signals of the shared 11011 detector scheduler.
// master = requesters plus detector (testbench side), slave = scheduler.
interface seq_detect_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] word_in;
  logic [NUM_REQ-1:0]        grant;
  logic                      det_clear;
  logic                      det_inp;
  logic                      det_out;
  logic                      busy;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          match_cnt;

  modport master (
    output req, word_in, det_out,
    input  grant, det_clear, det_inp, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, word_in, det_out,
    output grant, det_clear, det_inp, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler feeding one 11011 Mealy detector; result WORD_W+2 cycles after capture.
// Requests are level-held and wait while busy; one word per WORD_W+3 cycles.
module seq_detect_sched #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4
) (
  input logic               clk_pulse,
  input logic               clear_n,
  seq_detect_sched_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic [WORD_W-1:0]  shreg;
  logic [BC_W-1:0]    bitcnt;
  logic [NUM_REQ-1:0] grant;
  logic               det_clear;
  logic               det_inp;
  logic               busy;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic [CNT_W-1:0]   match_cnt;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_pulse or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      grant     <= '0;
      det_clear <= 1'b1;
      det_inp   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= FLUSH;
            winner    <= pick;
            ptr       <= (pick == ID_W'(NUM_REQ-1)) ? '0 : pick + 1'b1;
            shreg     <= bus.word_in[int'(pick)*WORD_W +: WORD_W];
            grant     <= NUM_REQ'(1) << pick;
            busy      <= 1'b1;
            det_clear <= 1'b1;
            match_cnt <= '0;
            bitcnt    <= '0;
          end
        end
        FLUSH: begin
          state     <= SHIFT;
          det_clear <= 1'b0;
          det_inp   <= shreg[WORD_W-1];
          shreg     <= shreg << 1;
        end
        SHIFT: begin
          if (bus.det_out && match_cnt != '1) begin
            match_cnt <= match_cnt + 1'b1;
          end
          bitcnt <= bitcnt + 1'b1;
          // The edge ending the last bit also moves to DONE so done lands WORD_W+2 after capture.
          if (bitcnt == BC_W'(WORD_W-1)) begin
            state     <= DONE;
            det_clear <= 1'b1;
            det_inp   <= 1'b0;
            done      <= 1'b1;
            done_id   <= winner;
          end else begin
            det_inp <= shreg[WORD_W-1];
            shreg   <= shreg << 1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant;
  assign bus.det_clear = det_clear;
  assign bus.det_inp   = det_inp;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.done_id   = done_id;
  assign bus.match_cnt = match_cnt;
endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shares one 11011 overlapping Mealy sequence detector between NUM_REQ requesters.
- Arbitrates round-robin and captures the granted requester's parallel word.
- Clears the detector, then serializes the word MSB-first onto the detector input.
- Counts detector output pulses and returns the match count tagged with the requester ID. It sits directly in front of the detector instance and owns its clear and input lines.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- WORD_W, 8, bits per word shifted into the detector.
- CNT_W, 4, match-counter width; saturates at 2^CNT_W-1.
- Derived: ID_W = max(1, clog2(NUM_REQ)).

Ports:
- clk_pulse  in  1  single clock; all state updates on rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held high until grant.
- word_in  in  NUM_REQ*WORD_W  packed words; requester i at bits [i*WORD_W +: WORD_W]; held stable while req[i]=1.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: word captured.
- det_clear  out  1  active-high clear to detector.
- det_inp  out  1  serial bit to detector input.
- det_out  in  1  detector Mealy output; combinational on det_inp in the same cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: result valid.
- done_id  out  ID_W  requester index of the finished word.
- match_cnt  out  CNT_W  matches detected in the finished word.

Behaviour:
- Reset (clear_n=0, async): state=IDLE, rr pointer=0, grant=0, det_clear=1, det_inp=0, busy=0, done=0, done_id=0, match_cnt=0, shift register and bit counter=0.
- FSM states: IDLE, FLUSH, SHIFT, DONE. All outputs are registered.
- IDLE:
  - det_clear=1.
  - On an edge with req!=0, pick the first set req at or after the pointer, wrapping.
  - Capture that requester's word into the shift register and go to FLUSH.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - req sampled only at that edge; a req dropped earlier is ignored.
- FLUSH (1 cycle):
  - grant[winner]=1, det_clear=1, match_cnt cleared to 0, bit counter=0, busy=1.
  - Guarantees the detector sees clear on at least one edge before the first bit.
  - Next state: SHIFT.
- SHIFT (exactly WORD_W cycles):
  - det_clear=0; det_inp = shift register MSB.
  - Each edge: if det_out=1, increment match_cnt, saturating.
  - Each edge: shift left, increment bit counter.
  - After the WORD_W-th edge, go to DONE.
- DONE (1 cycle): done=1, done_id=winner, det_clear=1, det_inp=0. Next state: IDLE.
- match_cnt and done_id hold their values until the next FLUSH.
- Latency:
  - Capture edge = cycle 0; FLUSH = cycle 1.
  - Bits presented in cycles 2..WORD_W+1.
  - done in cycle WORD_W+2.
  - Next capture no earlier than the edge ending the IDLE cycle after DONE, i.e. one word per WORD_W+3 cycles.
- det_out is ignored outside SHIFT.
- Matches never span words: the detector is cleared between every word.
- Requests arriving while busy wait; no queueing beyond the req level.
- Reset mid-operation: immediate return to reset values, no done, word discarded, pointer back to 0.

Test Plan:
- Reset: hold clear_n=0 with req=2'b11 -> grant=0, det_clear=1, det_inp=0, busy=0, done=0, match_cnt=0; no grant until clear_n=1.
- Single word: req=2'b01, word0=8'hDB -> grant[0] pulses cycle 1, det_clear high cycle 1, det_inp=1,1,0,1,1,0,1,1 in cycles 2-9, done cycle 10 with match_cnt=2, done_id=0.
- Contention: req=2'b11 after reset, word0=8'hDB, word1=8'h00 -> req0 served first (match_cnt=2, id 0), then req1 (match_cnt=0, id 1). Re-raise both -> req0 served first again.
- No cross-word match: word0=8'h06 then word1=8'hC0, back-to-back -> both match_cnt=0, even though the concatenated stream contains 11011.
- Saturation: CNT_W=1, word0=8'hDB -> match_cnt=1; with WORD_W=16, word=16'hDB6D -> match_cnt=1.
- Mid-shift reset: clear_n=0 after the 4th SHIFT bit -> outputs at reset values immediately, no done. After release with req=2'b11, grant[0] first.
